ans_encoder: RTL

- rANS encoder; the upstream stage of `ans_decoder`.
- Consumes one symbol per transaction and maintains the rANS state.
- Emits 4-bit renormalisation nibbles and, on the last symbol, the final state.
- Host reverses symbol order before encoding and reverses the nibble stream before decoding. Reversed, the final state arrives LSB nibble first, which matches the decoder's state read order.
- Uses the same packed counts/cumulative tables as the decoder.

---
 rtl/ans_encoder.sv | 231 +++++++++++++++++++++++
 1 files changed

// File: rtl/ans_encoder.sv
// rANS encoder: one symbol per transaction, 4-bit renormalisation nibbles,
// and a final-state flush (MSB nibble first) on the last symbol of a block.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   ena                  clock enable; low freezes every register
//   in, in_last, in_vld  symbol input, end-of-block marker, valid
//   in_rdy               encoder ready for a symbol
//   out, out_last        output nibble, high with the final flush nibble
//   out_vld, out_rdy     output valid / downstream ready
//   counts_unpacked      count[j] at bits [j*CNT_WIDTH +: CNT_WIDTH]
//   cumulative_unpacked  inclusive cumulative counts, same packing
//   err                  sticky: a symbol with count 0 was presented
module ans_encoder #(
   parameter int unsigned SYM_WIDTH   = 4,
   parameter int unsigned CNT_WIDTH   = 4,
   parameter int unsigned SYM_COUNT   = 16,
   parameter int unsigned STATE_WIDTH = 16
) (
   input  logic                                     clk,
   input  logic                                     rst_n,
   input  logic                                     ena,
   input  logic [SYM_WIDTH-1:0]                     in,
   input  logic                                     in_last,
   input  logic                                     in_vld,
   output logic                                     in_rdy,
   output logic [SYM_WIDTH-1:0]                     out,
   output logic                                     out_last,
   output logic                                     out_vld,
   input  logic                                     out_rdy,
   input  logic [CNT_WIDTH*SYM_COUNT-1:0]           counts_unpacked,
   input  logic [(CNT_WIDTH+SYM_WIDTH)*SYM_COUNT-1:0] cumulative_unpacked,
   output logic                                     err
);

   localparam int unsigned CUM_WIDTH = CNT_WIDTH + SYM_WIDTH;
   localparam int unsigned NIB_NUM   = STATE_WIDTH / 4;
   localparam int unsigned KW        = (NIB_NUM > 1) ? $clog2(NIB_NUM) : 1;
   localparam int unsigned DW        = $clog2(STATE_WIDTH);
   localparam int unsigned RW        = CNT_WIDTH + 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_RENORM,
      S_DIVIDE,
      S_COMBINE,
      S_FLUSH
   } state_e;

   state_e                 state_q, state_d;
   logic [STATE_WIDTH-1:0] x_q, x_d;
   logic [SYM_WIDTH-1:0]   sym_q, sym_d;
   logic                   last_q, last_d;
   logic [CNT_WIDTH-1:0]   rem_q, rem_d;
   logic [DW-1:0]          div_cnt_q, div_cnt_d;
   logic [KW-1:0]          k_q, k_d;
   logic                   err_q, err_d;
   logic                   load_init_q, load_init_d;
   logic                   in_rdy_q, in_rdy_d;
   logic [SYM_WIDTH-1:0]   out_q, out_d;
   logic                   out_vld_q, out_vld_d;
   logic                   out_last_q, out_last_d;

   // Unpacked views of the frequency tables
   logic [CNT_WIDTH-1:0]   cnt_tab [SYM_COUNT];
   logic [CUM_WIDTH-1:0]   cum_tab [SYM_COUNT];

   for (genvar j = 0; j < SYM_COUNT; j++) begin : g_tab
      assign cnt_tab[j] = counts_unpacked[j*CNT_WIDTH +: CNT_WIDTH];
      assign cum_tab[j] = cumulative_unpacked[j*CUM_WIDTH +: CUM_WIDTH];
   end

   logic [CUM_WIDTH-1:0]   m_tot;
   logic [CNT_WIDTH-1:0]   cnt_cur;
   logic [CUM_WIDTH-1:0]   cum_lo_cur;
   logic [STATE_WIDTH-1:0] bound_cur;
   logic [RW-1:0]          rem_sh;
   logic [RW-1:0]          cnt_ext;
   logic                   in_xfer;
   logic                   out_xfer;
   logic [STATE_WIDTH-1:0] bound_nxt;

   assign m_tot      = cum_tab[SYM_COUNT-1];
   assign cnt_cur    = cnt_tab[sym_q];
   assign cum_lo_cur = (sym_q == '0) ? '0 : cum_tab[sym_q - SYM_WIDTH'(1)];
   assign bound_cur  = STATE_WIDTH'(cnt_cur) << 4;
   assign in_xfer    = in_rdy_q & in_vld;
   assign out_xfer   = out_vld_q & out_rdy;

   // Restoring division: bring the next dividend bit into the partial remainder
   assign rem_sh  = {rem_q, x_q[STATE_WIDTH-1]};
   assign cnt_ext = RW'(cnt_cur);

   // State register; ena freezes everything
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         x_q         <= '0;
         sym_q       <= '0;
         last_q      <= 1'b0;
         rem_q       <= '0;
         div_cnt_q   <= '0;
         k_q         <= '0;
         err_q       <= 1'b0;
         load_init_q <= 1'b1;
         in_rdy_q    <= 1'b1;
         out_q       <= '0;
         out_vld_q   <= 1'b0;
         out_last_q  <= 1'b0;
      end else if (ena) begin
         state_q     <= state_d;
         x_q         <= x_d;
         sym_q       <= sym_d;
         last_q      <= last_d;
         rem_q       <= rem_d;
         div_cnt_q   <= div_cnt_d;
         k_q         <= k_d;
         err_q       <= err_d;
         load_init_q <= load_init_d;
         in_rdy_q    <= in_rdy_d;
         out_q       <= out_d;
         out_vld_q   <= out_vld_d;
         out_last_q  <= out_last_d;
      end
   end

   // Next-state logic, plus output registers computed for the state being entered
   always_comb begin
      state_d     = state_q;
      // x is seeded with M on the first enabled cycle after reset
      x_d         = load_init_q ? STATE_WIDTH'(m_tot) : x_q;
      sym_d       = sym_q;
      last_d      = last_q;
      rem_d       = rem_q;
      div_cnt_d   = div_cnt_q;
      k_d         = k_q;
      err_d       = err_q;
      load_init_d = 1'b0;
      in_rdy_d    = 1'b0;
      out_d       = out_q;
      out_vld_d   = 1'b0;
      out_last_d  = 1'b0;
      bound_nxt   = '0;

      unique case (state_q)
         S_IDLE: begin
            if (in_xfer) begin
               sym_d  = in;
               last_d = in_last;
               // Zero-probability symbols cannot be coded: flag and drop
               if (cnt_tab[in] == '0) begin
                  err_d = 1'b1;
               end else begin
                  state_d = S_RENORM;
               end
            end
         end

         S_RENORM: begin
            if (x_q >= bound_cur) begin
               if (out_xfer) begin
                  x_d = x_q >> 4;
               end
            end else begin
               state_d   = S_DIVIDE;
               rem_d     = '0;
               div_cnt_d = '0;
            end
         end

         S_DIVIDE: begin
            // x_q doubles as dividend shifter and quotient accumulator
            if (rem_sh >= cnt_ext) begin
               rem_d = CNT_WIDTH'(rem_sh - cnt_ext);
               x_d   = {x_q[STATE_WIDTH-2:0], 1'b1};
            end else begin
               rem_d = CNT_WIDTH'(rem_sh);
               x_d   = {x_q[STATE_WIDTH-2:0], 1'b0};
            end
            div_cnt_d = div_cnt_q + DW'(1);
            if (div_cnt_q == DW'(STATE_WIDTH - 1)) begin
               state_d = S_COMBINE;
            end
         end

         S_COMBINE: begin
            x_d = (x_q * STATE_WIDTH'(m_tot)) + STATE_WIDTH'(cum_lo_cur)
                + STATE_WIDTH'(rem_q);
            if (last_q) begin
               state_d = S_FLUSH;
               k_d     = KW'(NIB_NUM - 1);
            end else begin
               state_d = S_IDLE;
            end
         end

         S_FLUSH: begin
            if (out_xfer) begin
               if (k_q != '0) begin
                  k_d = k_q - KW'(1);
               end else begin
                  x_d     = STATE_WIDTH'(m_tot);
                  state_d = S_IDLE;
               end
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase

      in_rdy_d  = (state_d == S_IDLE);
      bound_nxt = STATE_WIDTH'(cnt_tab[sym_d]) << 4;
      if ((state_d == S_RENORM) && (x_d >= bound_nxt)) begin
         out_vld_d = 1'b1;
         out_d     = SYM_WIDTH'(x_d[3:0]);
      end else if (state_d == S_FLUSH) begin
         out_vld_d  = 1'b1;
         out_d      = SYM_WIDTH'(x_d >> {k_d, 2'b00});
         out_last_d = (k_d == '0);
      end
   end

   assign in_rdy   = in_rdy_q;
   assign out      = out_q;
   assign out_vld  = out_vld_q;
   assign out_last = out_last_q;
   assign err      = err_q;

endmodule
